i2c_slave: RTL

- I2C target (slave) that answers the bus traffic generated by our I2C master: device-address match, register-pointer write, data writes, and repeated-start reads.
- Bridges the open-drain scl/sda pins to a simple 256-entry register-file port: an address, a one-cycle write strobe, and combinational read data.
- Sits on the board side of the same two-wire bus, so one FPGA can loop back master traffic or emulate a sensor.
- No clock stretching: scl is input only, and sda is the only pin this block drives.

---
 rtl/i2c_slave_if.sv | 31 +++
 rtl/i2c_slave.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: groups the I2C clock input and the register-file port of the
// i2c_slave target.
//   scl      - I2C clock pin, only sampled by the target
//   reg_addr - register pointer presented to the register file
//   wr_data  - byte received from the bus master
//   wr_en    - one-clk write strobe qualifying reg_addr/wr_data
//   rd_data  - register contents at reg_addr (combinational from the regfile)
//   busy     - target is currently addressed
//   ack_e    - master NACKed the last read byte (sticky until next START)
//   led      - current FSM state encoding, for debug
// The open-drain sda pin is a plain inout port on the target itself.
interface i2c_slave_if;
  logic       scl;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic [7:0] rd_data;
  logic       busy;
  logic       ack_e;
  logic [3:0] led;

  modport slave (
    input  scl, rd_data,
    output reg_addr, wr_data, wr_en, busy, ack_e, led
  );

  modport master (
    output scl, rd_data,
    input  reg_addr, wr_data, wr_en, busy, ack_e, led
  );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target that answers address match, register-pointer write,
// data writes and repeated-start reads, bridging the two-wire bus to a
// 256-entry register-file port. No clock stretching; sda is only pulled low.
//   clk   - system clock, at least 16x the scl frequency
//   reset - synchronous, active-low reset
//   sda   - open-drain I2C data pin (driven 1'b0 or released to 1'bz)
//   bus   - i2c_slave_if.slave: scl input plus the register-file port
module i2c_slave #(
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         sda,
  i2c_slave_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    PTR      = 4'd3,
    PTR_ACK  = 4'd4,
    WR       = 4'd5,
    WR_ACK   = 4'd6,
    RD       = 4'd7,
    RD_ACK   = 4'd8
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_dly_q, sda_dly_q;
  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s, count_state_s;

  state_t     state_q, state_d;
  logic [7:0] ptr_q, ptr_d, shift_q, shift_d, wr_data_q, wr_data_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       sda_oe_q, sda_oe_d, wr_en_q, wr_en_d;
  logic       busy_q, busy_d, ack_e_q, ack_e_d, rw_q, rw_d;

  // Synchronisers reset to the idle-bus level so reset itself creates no event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_dly_q;
  assign scl_fall_s = ~scl_s & scl_dly_q;
  // scl must be high on both samples so an sda change near an scl edge is not
  // mistaken for START/STOP.
  assign start_s    = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_s     = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
  assign count_state_s = (state_q == ADDR) || (state_q == PTR) ||
                         (state_q == WR)   || (state_q == RD);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= 8'h00;
      shift_q   <= 8'h00;
      wr_data_q <= 8'h00;
      cnt_q     <= 3'd0;
      done_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      ack_e_q   <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      shift_q   <= shift_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      ack_e_q   <= ack_e_d;
      rw_q      <= rw_d;
    end
  end

  // Next-state logic; START/STOP are applied last so they override everything.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    shift_d   = shift_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    ack_e_d   = ack_e_q;
    rw_d      = rw_q;

    // The write strobe shows the old pointer; advance it one clk later.
    if (wr_en_q) begin
      ptr_d = ptr_q + 8'd1;
    end else begin
      ptr_d = ptr_q;
    end

    // Bit counter; in RD the shifter holds outgoing data and is not shifted here.
    if (scl_rise_s && count_state_s && !done_q) begin
      cnt_d  = cnt_q + 3'd1;
      done_d = (cnt_q == 3'd7);
      if (state_q != RD) begin
        shift_d = {shift_q[6:0], sda_s};
      end else begin
        shift_d = shift_q;
      end
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      IDLE: state_d = IDLE;
      ADDR: begin
        if (scl_fall_s && done_q) begin
          done_d = 1'b0;
          if (shift_q[7:1] == DEV_ADDR) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            rw_d     = shift_q[0];
            state_d  = ADDR_ACK;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          state_d = ADDR;
        end
      end
      ADDR_ACK: begin
        if (scl_fall_s) begin
          if (rw_q) begin
            shift_d  = bus.rd_data;
            sda_oe_d = ~bus.rd_data[7];
            state_d  = RD;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = PTR;
          end
        end else begin
          state_d = ADDR_ACK;
        end
      end
      PTR: begin
        if (scl_fall_s && done_q) begin
          ptr_d    = shift_q;
          done_d   = 1'b0;
          sda_oe_d = 1'b1;
          state_d  = PTR_ACK;
        end else begin
          state_d = PTR;
        end
      end
      PTR_ACK, WR_ACK: begin
        if (scl_fall_s) begin
          sda_oe_d = 1'b0;
          state_d  = WR;
        end else begin
          state_d = state_q;
        end
      end
      WR: begin
        if (scl_fall_s && done_q) begin
          done_d    = 1'b0;
          sda_oe_d  = 1'b1;
          wr_data_d = shift_q;
          wr_en_d   = 1'b1;
          state_d   = WR_ACK;
        end else begin
          state_d = WR;
        end
      end
      RD: begin
        if (scl_fall_s && done_q) begin
          done_d   = 1'b0;
          sda_oe_d = 1'b0;
          state_d  = RD_ACK;
        end else if (scl_fall_s) begin
          shift_d  = {shift_q[6:0], 1'b0};
          sda_oe_d = ~shift_q[6];
        end else begin
          state_d = RD;
        end
      end
      RD_ACK: begin
        if (scl_rise_s) begin
          ptr_d   = ptr_q + 8'd1;
          ack_e_d = ack_e_q | sda_s;
        end else if (scl_fall_s) begin
          // ack_e can only be set by this byte: it was cleared at START.
          if (ack_e_q) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            shift_d  = bus.rd_data;
            sda_oe_d = ~bus.rd_data[7];
            state_d  = RD;
          end
        end else begin
          state_d = RD_ACK;
        end
      end
      default: begin
        sda_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (start_s) begin
      state_d  = ADDR;
      cnt_d    = 3'd0;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
      ack_e_d  = 1'b0;
    end else if (stop_s) begin
      state_d  = IDLE;
      cnt_d    = 3'd0;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  assign sda          = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.reg_addr = ptr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.busy     = busy_q;
  assign bus.ack_e    = ack_e_q;
  assign bus.led      = state_q;

endmodule
